// File: rtl/fifo2core_regs_if.sv
// FIFO-side and transceiver-side handshake bundle of the core register endpoint.
// master = the register endpoint, slave = FIFOs plus SL transmitter/receiver.
interface fifo2core_regs_if;
  logic        fifo_read_empty;
  logic [33:0] fifo_read_data;
  logic        fifo_read_inc;
  logic        fifo_write_full;
  logic [33:0] fifo_write_data;
  logic        fifo_write_inc;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;

  modport master (
    input  fifo_read_empty, fifo_read_data, fifo_write_full, tx_ready, rx_data, rx_valid,
    output fifo_read_inc, fifo_write_data, fifo_write_inc, tx_data, tx_valid
  );
  modport slave (
    output fifo_read_empty, fifo_read_data, fifo_write_full, tx_ready, rx_data, rx_valid,
    input  fifo_read_inc, fifo_write_data, fifo_write_inc, tx_data, tx_valid
  );
endinterface

// File: rtl/fifo2core_regs.sv
// Core-side endpoint of the APB/async-FIFO bridge: pops command words into
// config/channel/TX registers and pushes echoes, RX words and status changes back.
module fifo2core_regs #(
  parameter int CFG_W  = 16,
  parameter int CHAN_W = 2,
  parameter int STAT_W = 14
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  fifo2core_regs_if.master     bus,
  output logic [CFG_W-1:0]     config_o,
  output logic [CHAN_W-1:0]    channel_o,
  input  logic [STAT_W-1:0]    status_i
);
  localparam int SW = STAT_W + 2;

  typedef enum logic {R_IDLE, R_POP}  rd_st_e;
  typedef enum logic {W_IDLE, W_PUSH} wr_st_e;

  rd_st_e            rd_st_q;
  wr_st_e            wr_st_q;
  logic              rd_inc_q, wr_inc_q;
  logic [33:0]       wr_data_q, wr_data_d;
  logic [CFG_W-1:0]  cfg_q;
  logic [CHAN_W-1:0] chan_q;
  logic [31:0]       tx_data_q, rx_buf_q;
  logic              tx_valid_q;
  logic              echo_pend_q, echo_chan_q, rx_pend_q;
  logic              rx_ovr_q, cmd_err_q;
  logic [SW-1:0]     last_stat_q, stat_word;
  logic [1:0]        mod;
  logic              stat_pend, pop_go, push_go, push_echo, push_rx, push_stat;

  assign mod       = bus.fifo_read_data[33:32];
  assign stat_word = {rx_ovr_q, cmd_err_q, status_i};
  assign stat_pend = (stat_word != last_stat_q);

  // A data word waits behind an unaccepted TX word to keep command order.
  assign pop_go  = (rd_st_q == R_IDLE) && !bus.fifo_read_empty && !echo_pend_q &&
                   ((mod != 2'd1) || !tx_valid_q);
  assign push_go = (wr_st_q == W_IDLE) && !bus.fifo_write_full &&
                   (echo_pend_q || rx_pend_q || stat_pend);
  assign push_echo = push_go && echo_pend_q;
  assign push_rx   = push_go && !echo_pend_q && rx_pend_q;
  assign push_stat = push_go && !echo_pend_q && !rx_pend_q;

  always_comb begin
    wr_data_d = '0;
    if (push_echo)
      wr_data_d = echo_chan_q ? {2'd3, {(32-CHAN_W){1'b0}}, chan_q}
                              : {2'd0, {(32-CFG_W){1'b0}}, cfg_q};
    else if (push_rx)
      wr_data_d = {2'd1, rx_buf_q};
    else if (push_stat)
      wr_data_d = {2'd2, {(32-SW){1'b0}}, stat_word};
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rd_st_q     <= R_IDLE;
      wr_st_q     <= W_IDLE;
      rd_inc_q    <= 1'b0;
      wr_inc_q    <= 1'b0;
      wr_data_q   <= '0;
      cfg_q       <= '0;
      chan_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      rx_buf_q    <= '0;
      echo_pend_q <= 1'b0;
      echo_chan_q <= 1'b0;
      rx_pend_q   <= 1'b0;
      rx_ovr_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      last_stat_q <= '0;
    end else begin
      if (tx_valid_q && bus.tx_ready) tx_valid_q <= 1'b0;

      case (rd_st_q)
        R_IDLE: if (pop_go) begin
          rd_st_q  <= R_POP;
          rd_inc_q <= 1'b1;
          case (mod)
            2'd0: begin
              cfg_q       <= bus.fifo_read_data[CFG_W-1:0];
              echo_pend_q <= 1'b1;
              echo_chan_q <= 1'b0;
            end
            2'd1: begin
              tx_data_q  <= bus.fifo_read_data[31:0];
              tx_valid_q <= 1'b1;
            end
            2'd3: begin
              chan_q      <= bus.fifo_read_data[CHAN_W-1:0];
              echo_pend_q <= 1'b1;
              echo_chan_q <= 1'b1;
            end
            default: cmd_err_q <= 1'b1;
          endcase
        end
        default: begin
          rd_st_q  <= R_IDLE;
          rd_inc_q <= 1'b0;
        end
      endcase

      // Pend flags clear on the edge that latches the push word; a capture on
      // that same edge re-arms rx_pend with the new word and is not an overrun.
      case (wr_st_q)
        W_IDLE: if (push_go) begin
          wr_st_q   <= W_PUSH;
          wr_inc_q  <= 1'b1;
          wr_data_q <= wr_data_d;
          if (push_echo) echo_pend_q <= 1'b0;
          if (push_rx)   rx_pend_q   <= 1'b0;
          if (push_stat) last_stat_q <= stat_word;
        end
        default: begin
          wr_st_q   <= W_IDLE;
          wr_inc_q  <= 1'b0;
          wr_data_q <= '0;
        end
      endcase

      if (bus.rx_valid) begin
        rx_buf_q  <= bus.rx_data;
        rx_pend_q <= 1'b1;
        if (rx_pend_q && !push_rx) rx_ovr_q <= 1'b1;
      end
    end
  end

  assign bus.fifo_read_inc   = rd_inc_q;
  assign bus.fifo_write_inc  = wr_inc_q;
  assign bus.fifo_write_data = wr_data_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.tx_valid        = tx_valid_q;
  assign config_o            = cfg_q;
  assign channel_o           = chan_q;
endmodule

// File: tb/tb_fifo2core_regs.sv
// Directed bench: FWFT command FIFO and return FIFO are modelled with queues,
// every expected word is hand-computed.
module tb_fifo2core_regs;
  logic        pclk = 1'b0;
  logic        preset_n;
  logic [15:0] config_o;
  logic [1:0]  channel_o;
  logic [13:0] status_i;

  int n_tests = 0;
  int n_fail  = 0;
  int b2b     = 0;
  logic prev_winc = 1'b0;

  logic [33:0] cmdq[$];
  logic [33:0] retq[$];

  fifo2core_regs_if bus();

  fifo2core_regs #(.CFG_W(16), .CHAN_W(2), .STAT_W(14)) dut (
    .pclk(pclk), .preset_n(preset_n), .bus(bus.master),
    .config_o(config_o), .channel_o(channel_o), .status_i(status_i)
  );

  always #5 pclk = ~pclk;

  // FIFO models act on the falling edge, away from the DUT's sampling edge.
  always @(negedge pclk) begin
    if (bus.fifo_read_inc && cmdq.size() > 0) void'(cmdq.pop_front());
    if (bus.fifo_write_inc) begin
      retq.push_back(bus.fifo_write_data);
      if (prev_winc) b2b++;
    end
    prev_winc = bus.fifo_write_inc;
    bus.fifo_read_empty = (cmdq.size() == 0);
    bus.fifo_read_data  = (cmdq.size() == 0) ? 34'd0 : cmdq[0];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic wait_ret(input int n, input string tag);
    for (int i = 0; i < 100 && retq.size() < n; i++) @(negedge pclk);
    chk(tag, retq.size(), n);
  endtask

  function automatic logic [33:0] ret_at(input int i);
    return (retq.size() > i) ? retq[i] : 34'h3_FFFF_FFFF;
  endfunction

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_cfg"},  config_o, 0);
    chk({tag, "_chan"}, channel_o, 0);
    chk({tag, "_txv"},  bus.tx_valid, 0);
    chk({tag, "_txd"},  bus.tx_data, 0);
    chk({tag, "_rinc"}, bus.fifo_read_inc, 0);
    chk({tag, "_winc"}, bus.fifo_write_inc, 0);
    chk({tag, "_wdat"}, bus.fifo_write_data, 0);
  endtask

  initial begin
    int got_pop;
    preset_n            = 1'b0;
    status_i            = '0;
    bus.fifo_write_full = 1'b0;
    bus.tx_ready        = 1'b0;
    bus.rx_valid        = 1'b0;
    bus.rx_data         = '0;
    bus.fifo_read_empty = 1'b1;
    bus.fifo_read_data  = '0;
    #1;
    chk_outs_zero("reset");
    cyc(3);
    preset_n = 1'b1;
    cyc(2);

    // 1: config write, echoed back
    cmdq.push_back({2'd0, 32'h0000_00A5});
    got_pop = 0;
    for (int i = 0; i < 20 && !got_pop; i++) begin
      @(negedge pclk);
      if (bus.fifo_read_inc) got_pop = 1;
    end
    chk("t1_pop", got_pop, 1);
    chk("t1_cfg_at_pop", config_o, 16'h00A5);
    wait_ret(1, "t1_nret");
    cyc(5);
    chk("t1_one_push", retq.size(), 1);
    chk("t1_echo", ret_at(0), {2'd0, 32'h0000_00A5});
    retq.delete();

    // 2: TX words held until accepted, order kept
    cmdq.push_back({2'd1, 32'hDEAD_BEEF});
    cmdq.push_back({2'd1, 32'h1234_5678});
    cyc(8);
    chk("t2_txv1", bus.tx_valid, 1);
    chk("t2_txd1", bus.tx_data, 32'hDEAD_BEEF);
    chk("t2_held", cmdq.size(), 1);
    bus.tx_ready = 1'b1;
    cyc(1);
    bus.tx_ready = 1'b0;
    chk("t2_txv_clr", bus.tx_valid, 0);
    cyc(4);
    chk("t2_txv2", bus.tx_valid, 1);
    chk("t2_txd2", bus.tx_data, 32'h1234_5678);
    chk("t2_drained", cmdq.size(), 0);
    bus.tx_ready = 1'b1;
    cyc(1);
    bus.tx_ready = 1'b0;
    cyc(2);
    chk("t2_txv_end", bus.tx_valid, 0);
    chk("t2_no_ret", retq.size(), 0);

    // 3: RX overrun while return FIFO full
    bus.fifo_write_full = 1'b1;
    bus.rx_valid = 1'b1; bus.rx_data = 32'h1111_1111;
    cyc(1);
    bus.rx_data = 32'h2222_2222;
    cyc(1);
    bus.rx_valid = 1'b0;
    cyc(3);
    chk("t3_full_hold", retq.size(), 0);
    bus.fifo_write_full = 1'b0;
    wait_ret(2, "t3_nret");
    cyc(4);
    chk("t3_two_push", retq.size(), 2);
    chk("t3_rx", ret_at(0), {2'd1, 32'h2222_2222});
    chk("t3_stat", ret_at(1), {2'd2, 32'h0000_8000});
    retq.delete();

    // 4: reserved modifier -> cmd_err
    cmdq.push_back({2'd2, 32'hFFFF_FFFF});
    wait_ret(1, "t4_nret");
    cyc(4);
    chk("t4_stat", ret_at(0), {2'd2, 32'h0000_C000});
    chk("t4_cfg", config_o, 16'h00A5);
    chk("t4_chan", channel_o, 2'd0);
    chk("t4_txv", bus.tx_valid, 0);
    chk("t4_popped", cmdq.size(), 0);
    retq.delete();

    // 5: echo, rx and status all pending -> priority order with gaps
    b2b = 0;
    bus.fifo_write_full = 1'b1;
    cmdq.push_back({2'd0, 32'h1234_BEEF});
    bus.rx_valid = 1'b1; bus.rx_data = 32'hA5A5_5A5A;
    status_i = 14'h0155;
    cyc(1);
    bus.rx_valid = 1'b0;
    cyc(5);
    chk("t5_cfg", config_o, 16'hBEEF);
    bus.fifo_write_full = 1'b0;
    wait_ret(3, "t5_nret");
    cyc(4);
    chk("t5_echo", ret_at(0), {2'd0, 32'h0000_BEEF});
    chk("t5_rx",   ret_at(1), {2'd1, 32'hA5A5_5A5A});
    chk("t5_stat", ret_at(2), {2'd2, 32'h0000_C155});
    chk("t5_gaps", b2b, 0);
    chk("t5_count", retq.size(), 3);
    retq.delete();

    // 6: reset with TX and RX work pending
    bus.fifo_write_full = 1'b1;
    cmdq.push_back({2'd1, 32'hCAFE_F00D});
    bus.rx_valid = 1'b1; bus.rx_data = 32'h7777_7777;
    cyc(1);
    bus.rx_valid = 1'b0;
    cyc(4);
    chk("t6_pre_txv", bus.tx_valid, 1);
    preset_n = 1'b0;
    status_i = '0;
    #1;
    chk_outs_zero("t6");
    cyc(2);
    preset_n = 1'b1;
    bus.fifo_write_full = 1'b0;
    cyc(10);
    chk("t6_no_push", retq.size(), 0);
    chk("t6_wdat_idle", bus.fifo_write_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
